// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//
// Shares one combinational alu_8bit between NUM_REQ requesters. Requests are
// granted round-robin, the winner's operands and opcode are registered onto the
// ALU inputs, and one cycle later the ALU result and carry are captured. They
// are then returned to the winner with a valid/ready handshake.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   RESP_TIMEOUT  cycles in RESP without resp_ready before the response is
//                 dropped; 0 disables the timeout
//
// Optional feature
//   ALU_FLAGS_EN  when defined, resp_flags = {S, Z, P, CY}. S is result[7].
//                 Z is set when result == 0. P is set on even parity of
//                 result. CY is the carry. When undefined, resp_flags is
//                 {3'b000, carry}.
//
// Ports
//   clk, rst_n                     rising-edge clock, async active-low reset
//   req_valid / req_ready          per-requester request handshake
//                                  (req_ready is one-hot, only in IDLE)
//   req_operand_a/_b, req_operation  packed per-requester operands/opcode
//   resp_valid / resp_ready        per-requester response handshake
//   resp_result, resp_carry,
//   resp_flags                     captured response data
//   resp_timeout                   1-cycle pulse when a response is dropped
//   alu_operand_a/_b,
//   alu_operation                  registered drive to alu_8bit
//   alu_result, alu_carry_out      combinational return from alu_8bit
//   busy                           high whenever an op is in flight
//   grant_id                       index of the current or last grant

module alu_req_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*8-1:0]       req_operand_a,
    input  logic [NUM_REQ*8-1:0]       req_operand_b,
    input  logic [NUM_REQ*4-1:0]       req_operation,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [7:0]                 resp_result,
    output logic                       resp_carry,
    output logic [3:0]                 resp_flags,
    output logic                       resp_timeout,
    output logic [7:0]                 alu_operand_a,
    output logic [7:0]                 alu_operand_b,
    output logic [3:0]                 alu_operation,
    input  logic [7:0]                 alu_result,
    input  logic                       alu_carry_out,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  next_ptr;
    logic            winner_found;
    logic [CNTW-1:0] resp_cnt;
    logic            handshake;
    logic            timeout_hit;
    logic [3:0]      flags_next;

    logic [7:0] op_a_arr [NUM_REQ];
    logic [7:0] op_b_arr [NUM_REQ];
    logic [3:0] op_c_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a_arr[i] = req_operand_a[i*8 +: 8];
        assign op_b_arr[i] = req_operand_b[i*8 +: 8];
        assign op_c_arr[i] = req_operation[i*4 +: 4];
    end

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDW'((int'(rr_ptr) + off) % NUM_REQ);
            if (!winner_found && req_valid[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef ALU_FLAGS_EN
    assign flags_next = {alu_result[7], (alu_result == 8'h00), ~^alu_result, alu_carry_out};
`else
    assign flags_next = {3'b000, alu_carry_out};
`endif

    // A handshake in the same cycle as the timeout wins, so the timeout is
    // qualified by the absence of resp_ready from the granted requester.
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        resp_valid  = '0;
        handshake   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (winner_found) begin
                    req_ready[winner] = 1'b1;
                    state_next        = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid[grant_id] = 1'b1;
                handshake            = resp_ready[grant_id];
                if (RESP_TIMEOUT != 0) begin
                    timeout_hit = !handshake && (resp_cnt == CNTW'(RESP_TIMEOUT - 1));
                end
                if (handshake || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU inputs and response data are only loaded on their own transitions,
    // so they hold the last op after it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_operation <= '0;
            resp_result   <= '0;
            resp_carry    <= 1'b0;
            resp_flags    <= '0;
            resp_timeout  <= 1'b0;
            resp_cnt      <= '0;
        end else begin
            state        <= state_next;
            resp_timeout <= timeout_hit;
            unique case (state)
                IDLE: begin
                    if (winner_found) begin
                        alu_operand_a <= op_a_arr[winner];
                        alu_operand_b <= op_b_arr[winner];
                        alu_operation <= op_c_arr[winner];
                        grant_id      <= winner;
                    end
                end
                EXEC: begin
                    resp_result <= alu_result;
                    resp_carry  <= alu_carry_out;
                    resp_flags  <= flags_next;
                    resp_cnt    <= '0;
                end
                RESP: begin
                    if (handshake || timeout_hit) begin
                        rr_ptr <= next_ptr;
                    end else begin
                        resp_cnt <= resp_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
//
// Drives alu_req_arbiter (3 requesters, response timeout 8) through directed
// scenarios and a randomized run. Expected grants come from a round-robin
// pointer kept in the bench, and expected responses come from a behavioural
// ALU applied to the winner's operands. Build with ALU_FLAGS_EN defined or
// undefined to match the design build.

module tb_alu_req_arbiter;

    localparam int  NR         = 3;
    localparam int  TO         = 8;
    localparam int  IDW        = $clog2(NR);
    localparam int  AW         = NR * 8;
    localparam int  OW         = NR * 4;
    localparam time CLK_PERIOD = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_ready;
    logic [AW-1:0]  req_operand_a = '0;
    logic [AW-1:0]  req_operand_b = '0;
    logic [OW-1:0]  req_operation = '0;
    logic [NR-1:0]  resp_valid;
    logic [NR-1:0]  resp_ready = '0;
    logic [7:0]     resp_result;
    logic           resp_carry;
    logic [3:0]     resp_flags;
    logic           resp_timeout;
    logic [7:0]     alu_operand_a;
    logic [7:0]     alu_operand_b;
    logic [3:0]     alu_operation;
    logic [7:0]     alu_result;
    logic           alu_carry_out;
    logic           busy;
    logic [IDW-1:0] grant_id;

    int  num_checks   = 0;
    int  num_failures = 0;
    int  model_rr     = 0;
    time accept_time  = 0;
    int  last_grant   = 0;
    logic [7:0] last_result = '0;
    logic       last_carry  = 1'b0;
    logic [3:0] last_flags  = '0;

    alu_req_arbiter #(
        .NUM_REQ      (NR),
        .RESP_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operand_a (req_operand_a),
        .req_operand_b (req_operand_b),
        .req_operation (req_operation),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_carry    (resp_carry),
        .resp_flags    (resp_flags),
        .resp_timeout  (resp_timeout),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    // Behavioural stand-in for alu_8bit; returns {carry, result}.
    function automatic logic [8:0] aluFn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0:    aluFn = {1'b0, a} + {1'b0, b};
            4'd1:    aluFn = {1'b0, a} - {1'b0, b};
            4'd2:    aluFn = {1'b0, a & b};
            4'd3:    aluFn = {1'b0, a | b};
            4'd4:    aluFn = {1'b0, a ^ b};
            4'd5:    aluFn = {a, 1'b0};
            4'd6:    aluFn = {a[0], 1'b0, a[7:1]};
            default: aluFn = {1'b0, a} + {1'b0, b} + {5'b00000, op};
        endcase
    endfunction

    always_comb {alu_carry_out, alu_result} = aluFn(alu_operand_a, alu_operand_b, alu_operation);

    function automatic logic [3:0] expFlags(input logic [7:0] r, input logic c);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(r[i]);
`ifdef ALU_FLAGS_EN
        return {r[7], (r == 8'h00), (ones % 2 == 0), c};
`else
        return {3'b000, c};
`endif
    endfunction

    function automatic int pickWinner(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[IDW'((ptr + k) % NR)]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int w);
        return NR'(1) << w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setOperands(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        req_operand_a = (req_operand_a & ~(AW'(8'hFF) << (8 * idx))) | (AW'(a) << (8 * idx));
        req_operand_b = (req_operand_b & ~(AW'(8'hFF) << (8 * idx))) | (AW'(b) << (8 * idx));
        req_operation = (req_operation & ~(OW'(4'hF) << (4 * idx))) | (OW'(op) << (4 * idx));
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_rr = 0;
    endtask

    // One transaction from IDLE. Called one time unit after a rising edge;
    // returns one time unit after the edge that puts the design back in IDLE.
    task automatic applyStimulus(input logic [NR-1:0] valid, input int delay,
                                 input logic [NR-1:0] other_ready, input bit hold);
        int         w;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [3:0] eop;
        logic [8:0] ex;
        logic [3:0] ef;
        resp_ready = other_ready;
        req_valid  = valid;
        #1;
        w = pickWinner(valid, model_rr);
        if (w < 0) begin
            checkOutput("idle_req_ready", 32'(req_ready), 32'(0));
            @(posedge clk);
            #1;
            checkOutput("idle_busy", 32'(busy), 32'(0));
            return;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(onehot(w)));
        ea  = 8'(req_operand_a >> (8 * w));
        eb  = 8'(req_operand_b >> (8 * w));
        eop = 4'(req_operation >> (4 * w));
        ex  = aluFn(ea, eb, eop);
        ef  = expFlags(ex[7:0], ex[8]);

        @(posedge clk);
        accept_time = $time;
        #1;
        if (!hold) req_valid = NR'($urandom);
        req_operand_a = AW'({$urandom, $urandom});
        req_operand_b = AW'({$urandom, $urandom});
        req_operation = OW'($urandom);
        #1;
        last_grant = int'(grant_id);
        checkOutput("exec_busy", 32'(busy), 32'(1));
        checkOutput("exec_grant_id", 32'(grant_id), 32'(w));
        checkOutput("exec_alu_a", 32'(alu_operand_a), 32'(ea));
        checkOutput("exec_alu_b", 32'(alu_operand_b), 32'(eb));
        checkOutput("exec_alu_op", 32'(alu_operation), 32'(eop));
        checkOutput("exec_req_ready", 32'(req_ready), 32'(0));
        checkOutput("exec_resp_valid", 32'(resp_valid), 32'(0));
        checkOutput("exec_timeout_clr", 32'(resp_timeout), 32'(0));

        @(posedge clk);
        #1;
        for (int k = 0; k < TO; k++) begin
            resp_ready = (k >= delay) ? (other_ready | onehot(w)) : (other_ready & ~onehot(w));
            #1;
            checkOutput("resp_valid", 32'(resp_valid), 32'(onehot(w)));
            checkOutput("resp_result", 32'(resp_result), 32'(ex[7:0]));
            checkOutput("resp_carry", 32'(resp_carry), 32'(ex[8]));
            checkOutput("resp_flags", 32'(resp_flags), 32'(ef));
            checkOutput("resp_busy", 32'(busy), 32'(1));
            checkOutput("resp_req_ready", 32'(req_ready), 32'(0));
            last_result = resp_result;
            last_carry  = resp_carry;
            last_flags  = resp_flags;
            @(posedge clk);
            #1;
            if (k >= delay) break;
        end
        checkOutput("done_resp_valid", 32'(resp_valid), 32'(0));
        checkOutput("done_busy", 32'(busy), 32'(0));
        checkOutput("done_timeout", 32'(resp_timeout), 32'(delay >= TO));
        model_rr = (w + 1) % NR;
    endtask

    initial begin
        #(CLK_PERIOD * 20000);
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_grants [4];
        time prev_time;
        exp_grants = '{0, 1, 0, 1};

        // Reset state
        doReset();
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_grant_id", 32'(grant_id), 32'(0));
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'(0));
        checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
        checkOutput("rst_alu_a", 32'(alu_operand_a), 32'(0));
        checkOutput("rst_resp_result", 32'(resp_result), 32'(0));
        checkOutput("rst_resp_flags", 32'(resp_flags), 32'(0));
        checkOutput("rst_resp_timeout", 32'(resp_timeout), 32'(0));

        // Single add: 33 + CC = FF, no carry
        setOperands(0, 8'h33, 8'hCC, 4'h0);
        applyStimulus(3'b001, 0, 3'b000, 1'b0);
        checkOutput("single_result", 32'(last_result), 32'h0000_00FF);
        checkOutput("single_carry", 32'(last_carry), 32'(0));
`ifdef ALU_FLAGS_EN
        checkOutput("single_flags", 32'(last_flags), 32'(4'b1010));
`else
        checkOutput("single_flags", 32'(last_flags), 32'(4'b0000));
`endif

        // Zero result with carry
        setOperands(0, 8'h80, 8'h80, 4'h0);
        applyStimulus(3'b001, 0, 3'b110, 1'b0);
        checkOutput("zc_result", 32'(last_result), 32'(0));
        checkOutput("zc_carry", 32'(last_carry), 32'(1));
`ifdef ALU_FLAGS_EN
        checkOutput("zc_flags", 32'(last_flags), 32'(4'b0111));
`else
        checkOutput("zc_flags", 32'(last_flags), 32'(4'b0001));
`endif

        // Contention: two requesters held valid, grants alternate every 3 cycles
        doReset();
        prev_time = 0;
        for (int i = 0; i < 4; i++) begin
            setOperands(0, 8'(i + 1), 8'h10, 4'h0);
            setOperands(1, 8'(i + 5), 8'h20, 4'h1);
            applyStimulus(3'b011, 0, 3'b111, 1'b1);
            checkOutput("contention_grant", 32'(last_grant), 32'(exp_grants[i]));
            if (i > 0) checkOutput("contention_spacing", 32'((accept_time - prev_time) / CLK_PERIOD), 32'(3));
            prev_time = accept_time;
        end

        // Backpressure for 3 cycles, then timeout with resp_ready held low
        setOperands(2, 8'hA5, 8'h3C, 4'h4);
        applyStimulus(3'b100, 3, 3'b011, 1'b0);
        setOperands(0, 8'h7F, 8'h01, 4'h0);
        applyStimulus(3'b001, 20, 3'b110, 1'b0);
        // Pointer advanced past requester 0 after the timeout
        setOperands(1, 8'h11, 8'h22, 4'h3);
        setOperands(2, 8'h44, 8'h08, 4'h1);
        applyStimulus(3'b111, 0, 3'b000, 1'b0);
        checkOutput("after_timeout_grant", 32'(last_grant), 32'(1));

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int r;
            int d;
            req_operand_a = AW'({$urandom, $urandom});
            req_operand_b = AW'({$urandom, $urandom});
            req_operation = OW'($urandom);
            r = int'($urandom_range(0, 9));
            d = (r == 9) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, 3));
            applyStimulus(NR'($urandom_range(0, (1 << NR) - 1)), d, NR'($urandom), 1'b0);
        end

        // Reset during EXEC aborts the op
        req_valid = '0;
        @(posedge clk);
        #1;
        setOperands(1, 8'h5A, 8'h0F, 4'h2);
        req_valid = 3'b010;
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'(0));
        checkOutput("abort_grant_id", 32'(grant_id), 32'(0));
        checkOutput("abort_alu_a", 32'(alu_operand_a), 32'(0));
        checkOutput("abort_alu_op", 32'(alu_operation), 32'(0));
        checkOutput("abort_resp_valid", 32'(resp_valid), 32'(0));
        checkOutput("abort_resp_result", 32'(resp_result), 32'(0));
        checkOutput("abort_req_ready", 32'(req_ready), 32'(0));
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_rr   = 0;
        resp_ready = '1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_resp", 32'(resp_valid), 32'(0));
            checkOutput("abort_idle", 32'(busy), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
        $finish;
    end

endmodule
